// File: rtl/ama_riscv_wb_arbiter.sv
// Register-file writeback arbiter: pipeline writes win, long-latency results queue in a FIFO,
// and a starvation counter forces a one-cycle pipeline stall so the FIFO always drains.
module ama_riscv_wb_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_valid,
    input  logic [4:0]  p_addr,
    input  logic [31:0] p_data,
    input  logic        m_valid,
    output logic        m_ready,
    input  logic [4:0]  m_addr,
    input  logic [31:0] m_data,
    output logic        rf_we,
    output logic [4:0]  rf_addr_d,
    output logic [31:0] rf_data_d,
    output logic        p_stall,
    output logic [31:0] pending_mask,
    output logic        wb_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    logic [4:0]       addr_mem [DEPTH];
    logic [31:0]      data_mem [DEPTH];
    logic [DEPTH-1:0] occ;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr;
    logic [CW-1:0]    starve_cnt;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             p_win;
    logic [31:0]      mask_acc;

    assign rd_idx  = rd_ptr[AW-1:0];
    assign wr_idx  = wr_ptr[AW-1:0];
    assign empty   = (rd_ptr == wr_ptr);
    assign full    = (rd_ptr[AW] != wr_ptr[AW]) && (rd_idx == wr_idx);
    assign m_ready = !full;
    assign push    = m_valid && !full && (m_addr != 5'd0);
    assign p_stall = (starve_cnt == STARVE_LIM);

    // A stalled pipeline loses the port, so a stall cycle always pops the head.
    assign p_win = p_valid && (p_addr != 5'd0) && !p_stall;
    assign pop   = !empty && !p_win;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_idx] <= m_addr;
            data_mem[wr_idx] <= m_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            occ        <= '0;
            starve_cnt <= '0;
            wb_err     <= 1'b0;
            rf_we      <= 1'b0;
            rf_addr_d  <= 5'd0;
            rf_data_d  <= 32'd0;
        end else begin
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                occ[rd_idx] <= 1'b0;
            end
            if (push) begin
                wr_ptr      <= wr_ptr + 1'b1;
                occ[wr_idx] <= 1'b1;
            end

            if (empty || pop) begin
                starve_cnt <= '0;
            end else if (starve_cnt != STARVE_LIM) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (p_valid && p_stall) begin
                wb_err <= 1'b1;
            end

            // Output register stage
            if (p_win) begin
                rf_we     <= 1'b1;
                rf_addr_d <= p_addr;
                rf_data_d <= p_data;
            end else if (pop) begin
                rf_we     <= 1'b1;
                rf_addr_d <= addr_mem[rd_idx];
                rf_data_d <= data_mem[rd_idx];
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

    always_comb begin
        mask_acc = 32'd0;
        for (int j = 0; j < DEPTH; j++) begin
            if (occ[j]) begin
                mask_acc = mask_acc | (32'd1 << addr_mem[j]);
            end
        end
        if (rf_we) begin
            mask_acc = mask_acc | (32'd1 << rf_addr_d);
        end
        pending_mask = mask_acc & ~32'd1;
    end

endmodule
